// File: rtl/dspl_sched.sv
// dspl_sched: display scheduler for the eight-digit multiplexed seven-segment driver.
//
// Two clients share the display:
// - a background client that continuously supplies a 32-bit hex value;
// - a message client that takes over the display for HOLD_MS milliseconds
//   through a level req / pulse ack handshake.
//
// Digit word layout: {dark, code[3:0], 1'b0}. Nibble [4k+3:4k] drives digit k+1.
//
// Optional feature macro: DSPL_SCHED_BLINK_EN.
// When it is defined, message digits blink with a half-period of BLINK_MS ms.
// When it is undefined, messages are shown steadily and BLINK_MS is only range-checked.

module dspl_sched #(
  parameter int MS_COUNT = 100000,  // clock cycles per millisecond tick
  parameter int HOLD_MS  = 2000,    // message display time in ms (>= 1)
  parameter int BLINK_MS = 250      // blink half-period in ms (>= 1)
) (
  input  logic        clock,
  input  logic        reset,        // asynchronous, active-low
  input  logic [31:0] bg_value,
  input  logic [7:0]  bg_blank,
  input  logic        lz_en,
  input  logic        msg_req,
  input  logic [31:0] msg_value,
  input  logic [7:0]  msg_blank,
  input  logic        msg_clr,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic [5:0]  d1,
  output logic [5:0]  d2,
  output logic [5:0]  d3,
  output logic [5:0]  d4,
  output logic [5:0]  d5,
  output logic [5:0]  d6,
  output logic [5:0]  d7,
  output logic [5:0]  d8
);

  // Reject parameter values that would make the timers meaningless.
  generate
    if (MS_COUNT < 1 || HOLD_MS < 1 || BLINK_MS < 1) begin : g_bad_params
      $error("dspl_sched: MS_COUNT, HOLD_MS and BLINK_MS must all be >= 1");
    end
  endgenerate

  localparam int PRESC_W = (MS_COUNT > 1) ? $clog2(MS_COUNT) : 1;
  localparam int HOLD_W  = (HOLD_MS  > 1) ? $clog2(HOLD_MS)  : 1;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(MS_COUNT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_MS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;  // background shown
  localparam logic [0:0] ST_HOLD = 1'b1;  // message shown

  localparam logic [5:0] DIGIT_DARK = 6'b100000;

  logic [0:0]         state_q;
  logic [PRESC_W-1:0] presc_q;
  logic [HOLD_W-1:0]  ms_cnt_q;
  logic [31:0]        msg_value_q;
  logic [7:0]         msg_blank_q;
  logic [7:0][5:0]    digit_q;

  logic       tick;       // one-cycle millisecond strobe
  logic       accept;     // request taken on this edge
  logic       leave;      // HOLD ends on this edge
  logic       blink_off;  // message digits forced dark this cycle
  logic [7:0] tail_zero;  // tail_zero[i]: nibbles i..7 of bg_value are all zero
  logic [7:0][5:0] bg_word;
  logic [7:0][5:0] msg_word;

  assign tick   = (presc_q == PRESC_MAX);
  assign accept = (state_q == ST_IDLE) && msg_req;
  // Timeout and msg_clr on the same edge still give a single exit.
  assign leave  = (state_q == ST_HOLD) && ((tick && (ms_cnt_q == HOLD_MAX)) || msg_clr);

  // Control FSM: IDLE -> HOLD on a request, HOLD -> IDLE on timeout or clear.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else if (accept) begin
      state_q <= ST_HOLD;
    end else if (leave) begin
      state_q <= ST_IDLE;
    end
  end

  // Millisecond prescaler: free-running, restarted when a message is accepted
  // so that HOLD lasts exactly HOLD_MS * MS_COUNT cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else if (accept || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Millisecond counter: counts ticks while holding, parked at zero otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ms_cnt_q <= '0;
    end else if (state_q != ST_HOLD || leave) begin
      ms_cnt_q <= '0;
    end else if (tick) begin
      ms_cnt_q <= ms_cnt_q + 1'b1;
    end
  end

  // Message latch: captured only on acceptance, so requests seen in HOLD
  // cannot disturb the message being shown.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      msg_value_q <= '0;
      msg_blank_q <= '0;
    end else if (accept) begin
      msg_value_q <= msg_value;
      msg_blank_q <= msg_blank;
    end
  end

  // Handshake outputs: ack pulses for one cycle, busy follows the HOLD state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      msg_ack  <= 1'b0;
      msg_busy <= 1'b0;
    end else begin
      msg_ack <= accept;
      if (accept) begin
        msg_busy <= 1'b1;
      end else if (leave) begin
        msg_busy <= 1'b0;
      end
    end
  end

`ifdef DSPL_SCHED_BLINK_EN
  localparam int BLINK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_MS - 1);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_dark_q;

  // Blink timer: cleared outside HOLD so every message starts in the visible phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt_q  <= '0;
      blink_dark_q <= 1'b0;
    end else if (state_q != ST_HOLD) begin
      blink_cnt_q  <= '0;
      blink_dark_q <= 1'b0;
    end else if (tick) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_q  <= '0;
        blink_dark_q <= ~blink_dark_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign blink_off = blink_dark_q;
`else
  assign blink_off = 1'b0;
`endif

  // Digit word builders for both clients, including leading-zero suppression.
  // NOTE: every variable gets a full assignment on each pass through this block,
  // otherwise synthesis would infer a latch to hold the unassigned bits.
  always_comb begin
    tail_zero = '0;
    bg_word   = '0;
    msg_word  = '0;
    tail_zero[7] = (bg_value[31:28] == 4'h0);
    for (int i = 6; i >= 0; i--) begin
      tail_zero[i] = tail_zero[i+1] && (bg_value[4*i +: 4] == 4'h0);
    end
    for (int i = 0; i < 8; i++) begin
      // Digit 1 is never suppressed, so a zero value still shows a single "0".
      bg_word[i]  = {bg_blank[i] | (lz_en && (i != 0) && tail_zero[i]),
                     bg_value[4*i +: 4], 1'b0};
      msg_word[i] = {msg_blank_q[i] | blink_off, msg_value_q[4*i +: 4], 1'b0};
    end
  end

  // Output digit registers: select by the pre-edge state, so a message appears
  // one edge after acceptance and background returns one edge after the exit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      digit_q <= {8{DIGIT_DARK}};
    end else if (state_q == ST_HOLD) begin
      digit_q <= msg_word;
    end else begin
      digit_q <= bg_word;
    end
  end

  assign d1 = digit_q[0];
  assign d2 = digit_q[1];
  assign d3 = digit_q[2];
  assign d4 = digit_q[3];
  assign d5 = digit_q[4];
  assign d6 = digit_q[5];
  assign d7 = digit_q[6];
  assign d8 = digit_q[7];

endmodule

// File: tb/tb_dspl_sched.sv
// tb_dspl_sched: self-checking bench for dspl_sched with MS_COUNT=4, HOLD_MS=3, BLINK_MS=1.
// Table-driven background vectors plus hand-written message sequences.
// Expected outputs go through a queue scoreboard, one entry per clock edge.

module tb_dspl_sched;

  localparam int MS_COUNT = 4;
  localparam int HOLD_MS  = 3;
  localparam int BLINK_MS = 1;

`ifdef DSPL_SCHED_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  // Packed as {d8, d7, ..., d1}.
  localparam logic [47:0] ALL_DARK = {8{6'h20}};
  localparam logic [47:0] BG1      = {6'h20, 6'h20, 6'h20, 6'h20, 6'h02, 6'h04, 6'h06, 6'h08};
  localparam logic [47:0] MSG_E    = {8{6'h1C}};
  localparam logic [47:0] MSG_1    = {8{6'h02}};
  localparam logic [47:0] MSG_2    = {6'h20, 6'h02, 6'h04, 6'h06, 6'h08, 6'h0A, 6'h0C, 6'h0E};

  logic        clock;
  logic        reset;
  logic [31:0] bg_value;
  logic [7:0]  bg_blank;
  logic        lz_en;
  logic        msg_req;
  logic [31:0] msg_value;
  logic [7:0]  msg_blank;
  logic        msg_clr;
  logic        msg_ack;
  logic        msg_busy;
  logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;
  logic [47:0] dout;

  assign dout = {d8, d7, d6, d5, d4, d3, d2, d1};

  dspl_sched #(
    .MS_COUNT(MS_COUNT),
    .HOLD_MS (HOLD_MS),
    .BLINK_MS(BLINK_MS)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bg_value (bg_value),
    .bg_blank (bg_blank),
    .lz_en    (lz_en),
    .msg_req  (msg_req),
    .msg_value(msg_value),
    .msg_blank(msg_blank),
    .msg_clr  (msg_clr),
    .msg_ack  (msg_ack),
    .msg_busy (msg_busy),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .d4       (d4),
    .d5       (d5),
    .d6       (d6),
    .d7       (d7),
    .d8       (d8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] bg;
    logic [7:0]  blank;
    logic        lz;
    logic [47:0] exp_d;
  } vec_t;

  typedef struct {
    logic        ack;
    logic        busy;
    logic [47:0] d;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic ack, input logic busy, input logic [47:0] d);
    exp_t e;
    e.ack  = ack;
    e.busy = busy;
    e.d    = d;
    sb.push_back(e);
  endtask

  // Advance one edge, then compare the DUT against the oldest expectation.
  task automatic step(input string name);
    exp_t e;
    @(posedge clock);
    #1;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got ack=%b busy=%b d=%h", name, msg_ack, msg_busy, dout);
    end else begin
      n_checks--;
      e = sb.pop_front();
      check({name, " ack"},  {47'd0, msg_ack},  {47'd0, e.ack});
      check({name, " busy"}, {47'd0, msg_busy}, {47'd0, e.busy});
      check({name, " d"},    dout,              e.d);
    end
  endtask

  // Message word seen n samples after acceptance; with blinking, the phase
  // flips every MS_COUNT*BLINK_MS = 4 cycles, starting visible.
  function automatic logic [47:0] msg_exp(input logic [47:0] vis, input int n);
    logic [47:0] r;
    r = vis;
    if (BLINK && (((n - 1) / (MS_COUNT * BLINK_MS)) % 2 == 1)) begin
      for (int k = 0; k < 8; k++) r[6*k+5] = 1'b1;
    end
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h0000_1234, 8'h00, 1'b1, BG1};
    vecs[1] = '{32'h0000_0000, 8'h00, 1'b1, {6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h00}};
    vecs[2] = '{32'h0000_0000, 8'h00, 1'b0, {8{6'h00}}};
    vecs[3] = '{32'h8000_0001, 8'h00, 1'b1, {6'h10, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h02}};
    vecs[4] = '{32'hFEDC_BA98, 8'hA5, 1'b0, {6'h3E, 6'h1C, 6'h3A, 6'h18, 6'h16, 6'h34, 6'h12, 6'h30}};
    vecs[5] = '{32'h0050_0000, 8'h00, 1'b1, {6'h20, 6'h20, 6'h0A, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00}};
    vecs[6] = '{32'h0000_0300, 8'h01, 1'b1, {6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h06, 6'h00, 6'h20}};

    reset     = 1'b0;
    bg_value  = 32'h0000_1234;
    bg_blank  = 8'h00;
    lz_en     = 1'b1;
    msg_req   = 1'b0;
    msg_value = 32'h0;
    msg_blank = 8'h00;
    msg_clr   = 1'b0;

    // Reset state.
    #12;
    check("reset d",    dout,                ALL_DARK);
    check("reset ack",  {47'd0, msg_ack},    48'd0);
    check("reset busy", {47'd0, msg_busy},   48'd0);
    @(posedge clock);
    #1;
    check("in reset d", dout, ALL_DARK);
    reset = 1'b1;

    // Background vectors: each input change shows up one edge later.
    for (int v = 0; v < 7; v++) begin
      bg_value = vecs[v].bg;
      bg_blank = vecs[v].blank;
      lz_en    = vecs[v].lz;
      push_exp(1'b0, 1'b0, vecs[v].exp_d);
      step($sformatf("bg vec %0d", v));
    end
    bg_value = 32'h0000_1234;
    bg_blank = 8'h00;
    lz_en    = 1'b1;
    push_exp(1'b0, 1'b0, BG1);
    step("bg restore");

    // Single message, request held only until the ack.
    msg_value = 32'hEEEE_EEEE;
    msg_blank = 8'h00;
    for (int c = 0; c <= 13; c++) begin
      msg_req = (c == 0);
      push_exp(c == 0, c <= 11, (c >= 1 && c <= 12) ? msg_exp(MSG_E, c) : BG1);
      step($sformatf("msgA c%0d", c));
    end

    // Back-to-back: second request raised mid-HOLD with new data on the bus.
    for (int c = 0; c <= 26; c++) begin
      msg_req   = (c == 0) || (c >= 5 && c <= 13);
      msg_value = (c == 0) ? 32'h1111_1111 : 32'h0123_4567;
      msg_blank = (c == 0) ? 8'h00 : 8'h80;
      if (c <= 12)
        push_exp(c == 0, c <= 11, (c >= 1) ? msg_exp(MSG_1, c) : BG1);
      else
        push_exp(c == 13, c <= 24, (c >= 14 && c <= 25) ? msg_exp(MSG_2, c - 13) : BG1);
      step($sformatf("msgB c%0d", c));
    end
    msg_req = 1'b0;

    // Clear alone in IDLE is ignored; req+clr together in IDLE is accepted;
    // clear five cycles into HOLD ends the message early.
    msg_value = 32'h1111_1111;
    msg_blank = 8'h00;
    msg_clr   = 1'b1;
    push_exp(1'b0, 1'b0, BG1);
    step("clr idle");
    for (int c = 0; c <= 7; c++) begin
      msg_req = (c == 0);
      msg_clr = (c == 0) || (c == 5);
      push_exp(c == 0, c <= 4, (c >= 1 && c <= 5) ? msg_exp(MSG_1, c) : BG1);
      step($sformatf("clrC c%0d", c));
    end
    msg_clr = 1'b0;

    // Clear coincident with timeout: one exit, nothing extra afterwards.
    for (int c = 0; c <= 16; c++) begin
      msg_req = (c == 0);
      msg_clr = (c == 12);
      push_exp(c == 0, c <= 11, (c >= 1 && c <= 12) ? msg_exp(MSG_1, c) : BG1);
      step($sformatf("clrTO c%0d", c));
    end
    msg_clr = 1'b0;

    // Reset in the middle of HOLD drops the message with no ack afterwards.
    for (int c = 0; c <= 4; c++) begin
      msg_req = (c == 0);
      push_exp(c == 0, 1'b1, (c >= 1) ? msg_exp(MSG_1, c) : BG1);
      step($sformatf("rstE c%0d", c));
    end
    reset = 1'b0;
    #2;
    check("mid reset d",    dout,              ALL_DARK);
    check("mid reset ack",  {47'd0, msg_ack},  48'd0);
    check("mid reset busy", {47'd0, msg_busy}, 48'd0);
    @(posedge clock);
    #1;
    check("held reset d", dout, ALL_DARK);
    reset = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      push_exp(1'b0, 1'b0, BG1);
      step($sformatf("after reset c%0d", c));
    end

    check("scoreboard drained", 48'(sb.size()), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
